// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes and multiply sequencer state encoding
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_LUI  = 4'b0010;
  localparam logic [3:0] ALU_ORI  = 4'b0011;
  localparam logic [3:0] ALU_SLLI = 4'b0100;
  localparam logic [3:0] ALU_SRLI = 4'b0101;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_ACC  = 3'd1,
    SEQ_SHL  = 3'd2,
    SEQ_SHR  = 3'd3,
    SEQ_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// rtl/alu_mul_sequencer.sv - shift-and-add multiply that borrows the shared ALU
module alu_mul_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  ready_o,
  output logic                  alu_req_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] product_o,
  output logic [3:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic                  alu_zero_i
);

  seq_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [DATA_WIDTH-1:0] prod_q, prod_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= SEQ_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  // Outputs decode only registered state, so start_i never reaches them combinationally.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    ready_o   = 1'b0;
    alu_req_o = 1'b0;
    done_o    = 1'b0;
    alu_op_o  = ALU_ADD;
    alu_a_o   = '0;
    alu_b_o   = '0;

    case (state_q)
      SEQ_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          mcand_d  = a_i;
          mplier_d = b_i;
          prod_d   = '0;
          if (b_i == '0)  state_d = SEQ_DONE;
          else if (b_i[0]) state_d = SEQ_ACC;
          else             state_d = SEQ_SHL;
        end
      end
      SEQ_ACC: begin
        alu_req_o = 1'b1;
        alu_op_o  = ALU_ADD;
        alu_a_o   = prod_q;
        alu_b_o   = mcand_q;
        prod_d    = alu_result_i;
        state_d   = SEQ_SHL;
      end
      SEQ_SHL: begin
        alu_req_o = 1'b1;
        alu_op_o  = ALU_SLLI;
        alu_a_o   = mcand_q;
        alu_b_o   = DATA_WIDTH'(1);
        mcand_d   = alu_result_i;
        state_d   = SEQ_SHR;
      end
      SEQ_SHR: begin
        // The zero flag on the shifted multiplier ends the loop early.
        alu_req_o = 1'b1;
        alu_op_o  = ALU_SRLI;
        alu_a_o   = mplier_q;
        alu_b_o   = DATA_WIDTH'(1);
        mplier_d  = alu_result_i;
        if (alu_zero_i)           state_d = SEQ_DONE;
        else if (alu_result_i[0]) state_d = SEQ_ACC;
        else                      state_d = SEQ_SHL;
      end
      SEQ_DONE: begin
        done_o  = 1'b1;
        state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign product_o = prod_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb/tb_alu_mul_sequencer.sv - directed bench for alu_mul_sequencer with an inline ALU model
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, alu_req_o, done_o;
  logic [31:0] product_o;
  logic [3:0]  alu_op_o;
  logic [31:0] alu_a_o, alu_b_o;
  logic [31:0] alu_result;
  logic        alu_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mul_sequencer #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset_n),
    .start_i     (start_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .ready_o     (ready_o),
    .alu_req_o   (alu_req_o),
    .done_o      (done_o),
    .product_o   (product_o),
    .alu_op_o    (alu_op_o),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_result_i(alu_result),
    .alu_zero_i  (alu_zero)
  );

  always_comb begin
    alu_result = 32'h0;
    case (alu_op_o)
      4'b0000: alu_result = alu_a_o + alu_b_o;
      4'b0001: alu_result = alu_a_o - alu_b_o;
      4'b0010: alu_result = alu_b_o << 12;
      4'b0011: alu_result = alu_a_o | alu_b_o;
      4'b0100: alu_result = alu_a_o << alu_b_o[4:0];
      4'b0101: alu_result = alu_a_o >> alu_b_o[4:0];
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  logic [3:0] ops_q[$];
  int         req_cnt;

  // Accept one multiply, then count cycles to done_o, logging ALU ops while granted.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int lat);
    ops_q.delete();
    req_cnt = 0;
    lat = 0;
    @(negedge clk);
    check("ready_before_start", {31'b0, ready_o}, 32'd1);
    start_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      if (alu_req_o) begin
        ops_q.push_back(alu_op_o);
        req_cnt++;
      end
      @(negedge clk);
      lat++;
    end
    if (!done_o) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: done_o not seen within %0d cycles", lat);
    end
  endtask

  vec_t vecs[10];
  logic [3:0] exp_ops[8];
  int lat;

  initial begin
    vecs[0] = '{32'd7,        32'd6,        32'd42,       9};
    vecs[1] = '{32'h1234,     32'd0,        32'd0,        1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        97};
    vecs[3] = '{32'd0,        32'd5,        32'd0,        9};
    vecs[4] = '{32'd3,        32'd1,        32'd3,        4};
    vecs[5] = '{32'd5,        32'd2,        32'd10,       6};
    vecs[6] = '{32'd1,        32'd3,        32'd3,        7};
    vecs[7] = '{32'h10,       32'h80000000, 32'd0,        66};
    vecs[8] = '{32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF, 37};
    vecs[9] = '{32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 10};
    exp_ops = '{4'b0100, 4'b0101, 4'b0000, 4'b0100, 4'b0101, 4'b0000, 4'b0100, 4'b0101};

    reset_n = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_req", {31'b0, alu_req_o}, 32'd0);
    check("rst_product", product_o, 32'd0);
    check("rst_alu_op", {28'b0, alu_op_o}, 32'd0);
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_b", alu_b_o, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'b0, ready_o}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_mul(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_product", i), product_o, vecs[i].prod);
      check($sformatf("v%0d_req_cycles", i), req_cnt, (vecs[i].b == 0) ? 0 : vecs[i].lat - 1);
      if (i == 0) begin
        check("mul7x6_op_count", ops_q.size(), 8);
        for (int j = 0; j < 8 && j < ops_q.size(); j++)
          check($sformatf("mul7x6_op%0d", j), {28'b0, ops_q[j]}, {28'b0, exp_ops[j]});
      end
      @(negedge clk);
      check($sformatf("v%0d_ready_after", i), {31'b0, ready_o}, 32'd1);
      check($sformatf("v%0d_product_held", i), product_o, vecs[i].prod);
    end

    // Start while busy must be dropped.
    @(negedge clk);
    start_i = 1'b1; a_i = 32'd2; b_i = 32'h80000000;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      if (lat == 5) begin start_i = 1'b1; a_i = 32'd3; b_i = 32'd5; end
      if (lat == 10) start_i = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ignored_latency", lat, 66);
    check("ignored_product", product_o, 32'd0);

    // start_i held: re-accept on the IDLE cycle right after DONE.
    @(negedge clk);
    start_i = 1'b1; a_i = 32'd3; b_i = 32'd1;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_o && lat < 200);
    check("b2b_first_latency", lat, 4);
    check("b2b_first_product", product_o, 32'd3);
    @(negedge clk);
    check("b2b_idle_ready", {31'b0, ready_o}, 32'd1);
    a_i = 32'd4; b_i = 32'd2;
    @(negedge clk);
    check("b2b_second_accepted", {31'b0, alu_req_o}, 32'd1);
    start_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_second_latency", lat, 6);
    check("b2b_second_product", product_o, 32'd8);

    // Reset pulled low during SHL: immediate IDLE, cleared product, no done.
    @(negedge clk);
    start_i = 1'b1; a_i = 32'd5; b_i = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("midrst_in_shl", {28'b0, alu_op_o}, 32'h4);
    reset_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready_o}, 32'd1);
    check("midrst_req", {31'b0, alu_req_o}, 32'd0);
    check("midrst_product", product_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    req_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o) req_cnt++;
    end
    check("midrst_no_done", req_cnt, 0);
    check("midrst_idle_after", {31'b0, ready_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
